// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises PLL lock and button, then releases NCH active-low
// reset channels in order. Define RST_SEQ_DEBOUNCE_EN to debounce the button input.
module rst_sequencer #(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_DLY    = 32,
    parameter int GAP         = 16,
    parameter int DEB_CYCLES  = 1024
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           locked_i,
    input  logic           btn_in,
    output logic [NCH-1:0] rst_on,
    output logic           ready_o,
    output logic [1:0]     cause_o,
    output logic [7:0]     abort_cnt_o
);

    localparam int MAX_AB = (LOCK_DLY > GAP) ? LOCK_DLY : GAP;
    localparam int MAXC   = (MAX_AB > DEB_CYCLES) ? MAX_AB : DEB_CYCLES;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic                   locked_s;
    logic                   btn_s;
    logic                   btn_d;
    logic                   ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_sync_q <= '0;
            btn_sync_q  <= '1;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked_i};
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign locked_s = lock_sync_q[SYNC_STAGES-1];
    assign btn_s    = btn_sync_q[SYNC_STAGES-1];

`ifdef RST_SEQ_DEBOUNCE_EN
    logic [CW-1:0] deb_cnt_q;
    logic          btn_d_q;

    // btn_d only follows btn_s after DEB_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deb_cnt_q <= '0;
            btn_d_q   <= 1'b1;
        end else if (btn_s != btn_d_q) begin
            if (deb_cnt_q == CW'(DEB_CYCLES - 1)) begin
                btn_d_q   <= btn_s;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + CW'(1);
            end
        end else begin
            deb_cnt_q <= '0;
        end
    end

    assign btn_d = btn_d_q;
`else
    assign btn_d = btn_s;
`endif

    assign ok = locked_s & btn_d;

    // state   | meaning
    // HOLD    | all channels in reset, waiting for ok
    // SETTLE  | lock stable, counting LOCK_DLY before first release
    // RELEASE | releasing channels 1..NCH-1, GAP cycles apart
    // RUN     | all channels released
    typedef enum logic [1:0] {
        S_HOLD,
        S_SETTLE,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [IW-1:0]  idx_q;
    logic [IW-1:0]  idx_d;
    logic [NCH-1:0] rst_on_q;
    logic           ready_q;
    logic [1:0]     cause_q;
    logic [7:0]     abort_cnt_q;

    assign idx_d = idx_q + IW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            rst_on_q    <= '0;
            ready_q     <= 1'b0;
            cause_q     <= 2'b00;
            abort_cnt_q <= 8'd0;
        end else if (state_q != S_HOLD && !ok) begin
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            idx_q    <= '0;
            rst_on_q <= '0;
            ready_q  <= 1'b0;
            cause_q  <= locked_s ? 2'b10 : 2'b01;
            if (abort_cnt_q != 8'hFF) begin
                abort_cnt_q <= abort_cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                S_HOLD: begin
                    cnt_q    <= '0;
                    idx_q    <= '0;
                    rst_on_q <= '0;
                    ready_q  <= 1'b0;
                    if (ok) begin
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == CW'(LOCK_DLY - 1)) begin
                        rst_on_q[0] <= 1'b1;
                        cnt_q       <= '0;
                        idx_q       <= '0;
                        if (NCH == 1) begin
                            state_q <= S_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= S_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == CW'(GAP - 1)) begin
                        cnt_q    <= '0;
                        idx_q    <= idx_d;
                        rst_on_q <= rst_on_q | (NCH'(1) << idx_d);
                        if (idx_d == IDX_LAST) begin
                            state_q <= S_RUN;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RUN: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q <= S_HOLD;
                end
            endcase
        end
    end

    assign rst_on      = rst_on_q;
    assign ready_o     = ready_q;
    assign cause_o     = cause_q;
    assign abort_cnt_o = abort_cnt_q;

endmodule
